operand_sequencer: RTL

//  Upstream stage of the Add block: collects two 3-bit sign-magnitude operands from board switches

---
 rtl/alu_pkg.sv | 15 +
 rtl/btn_debounce.sv | 44 ++++
 rtl/operand_sequencer.sv | 112 +++++++++++
 3 files changed

// File: rtl/alu_pkg.sv
// Shared types and constants for the Add front-end: operand/result widths and sequencer states.
package alu_pkg;

  localparam int OP_W  = 3;
  localparam int RES_W = 4;
  localparam logic [OP_W-1:0] NEG_ZERO = 3'b100;

  typedef enum logic [1:0] {
    S_A,
    S_B,
    S_SETTLE,
    S_DONE
  } state_t;

endpackage

// File: rtl/btn_debounce.sv
// Raw button -> 2-flop synchroniser -> stability counter -> one-cycle pulse on a debounced rise.
module btn_debounce #(
  parameter int DEBOUNCE_CYCLES = 4
) (
  input  logic clk,
  input  logic rst_n,
  input  logic btn,
  output logic pulse
);

  localparam int CW = (DEBOUNCE_CYCLES < 2) ? 1 : $clog2(DEBOUNCE_CYCLES);

  logic          sync1;
  logic          sync2;
  logic          level;
  logic [CW-1:0] cnt;

  // cnt counts consecutive cycles where the synchronised input disagrees with level
  always_ff @(posedge clk) begin
    if (!rst_n) begin
      sync1 <= 1'b0;
      sync2 <= 1'b0;
      level <= 1'b0;
      cnt   <= '0;
      pulse <= 1'b0;
    end else begin
      sync1 <= btn;
      sync2 <= sync1;
      pulse <= 1'b0;
      if (sync2 != level) begin
        if (cnt == CW'(DEBOUNCE_CYCLES - 1)) begin
          level <= sync2;
          cnt   <= '0;
          pulse <= sync2;
        end else begin
          cnt <= cnt + 1'b1;
        end
      end else begin
        cnt <= '0;
      end
    end
  end

endmodule

// File: rtl/operand_sequencer.sv
// Collects two sign-magnitude operands via a debounced LOAD button, feeds the external adder,
// waits a fixed settle time and latches the adder's result for display. CLEAR restarts.
module operand_sequencer
  import alu_pkg::*;
#(
  parameter int W               = OP_W,
  parameter int DEBOUNCE_CYCLES = 4,
  parameter int SETTLE_CYCLES   = 2
) (
  input  logic         clk,
  input  logic         rst_n,
  input  logic [W-1:0] sw_val,
  input  logic         load_btn,
  input  logic         clear_btn,
  input  logic [W:0]   add_result,
  input  logic         add_zero,
  output logic [W-1:0] num1,
  output logic [W-1:0] num2,
  output logic [W:0]   res_q,
  output logic         zero_q,
  output logic         need_a,
  output logic         need_b,
  output logic         done
);

  localparam int SCW = (SETTLE_CYCLES < 2) ? 1 : $clog2(SETTLE_CYCLES);
  localparam logic [W-1:0] NZ = {1'b1, {(W-1){1'b0}}};

  state_t         state_q;
  state_t         state_d;
  logic [SCW-1:0] settle_cnt;
  logic           load_p;
  logic           clear_p;
  logic [W-1:0]   sw_norm;

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_load_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (load_btn),
    .pulse (load_p)
  );

  btn_debounce #(.DEBOUNCE_CYCLES(DEBOUNCE_CYCLES)) u_clear_db (
    .clk   (clk),
    .rst_n (rst_n),
    .btn   (clear_btn),
    .pulse (clear_p)
  );

  // Negative zero is folded to +0 so the adder never sees two encodings of zero
  assign sw_norm = (sw_val == NZ) ? '0 : sw_val;

  always_ff @(posedge clk) begin
    if (!rst_n) begin
      state_q    <= S_A;
      num1       <= '0;
      num2       <= '0;
      res_q      <= '0;
      zero_q     <= 1'b0;
      settle_cnt <= '0;
    end else begin
      state_q <= state_d;
      if (clear_p) begin
        num1   <= '0;
        num2   <= '0;
        res_q  <= '0;
        zero_q <= 1'b0;
      end else begin
        case (state_q)
          S_A: if (load_p) num1 <= sw_norm;
          S_B: if (load_p) begin
            num2       <= sw_norm;
            settle_cnt <= SCW'(SETTLE_CYCLES - 1);
          end
          S_SETTLE: begin
            if (settle_cnt == '0) begin
              res_q  <= add_result;
              zero_q <= add_zero;
            end else begin
              settle_cnt <= settle_cnt - 1'b1;
            end
          end
          S_DONE: if (load_p) num1 <= sw_norm;
          default: ;
        endcase
      end
    end
  end

  // clear has priority; LOAD during SETTLE is deliberately dropped
  always_comb begin
    state_d = state_q;
    if (clear_p) begin
      state_d = S_A;
    end else begin
      case (state_q)
        S_A:      if (load_p) state_d = S_B;
        S_B:      if (load_p) state_d = S_SETTLE;
        S_SETTLE: if (settle_cnt == '0) state_d = S_DONE;
        S_DONE:   if (load_p) state_d = S_B;
        default:  state_d = S_A;
      endcase
    end
  end

  always_comb begin
    need_a = (state_q == S_A);
    need_b = (state_q == S_B);
    done   = (state_q == S_DONE);
  end

endmodule
